// File: rtl/soc_cfg_pkg.sv
// SoC-level DMA/AXI configuration shared by the cluster DMA blocks, plus the
// burst-splitting helper used by the sequencer and the R/W data movers.
package soc_cfg_pkg;

  localparam int AXI_AW            = 64;
  localparam int AXI_DW            = 64;
  localparam int DMA_MAX_BURST_LEN = 8;
  localparam int DMA_LEN_W         = 24;
  localparam int DMA_BYTES         = AXI_DW / 8;

  // Beats of the next burst starting at page offset addr: limited by what is
  // left, the burst cap, and the distance to the next 4 KiB page.
  function automatic logic [DMA_LEN_W-1:0] burst_beats(input logic [11:0]          addr,
                                                       input logic [DMA_LEN_W-1:0] beats_left);
    logic [DMA_LEN_W-1:0] to_4k;
    logic [DMA_LEN_W-1:0] beats;
    to_4k = (DMA_LEN_W'(13'h1000) - DMA_LEN_W'(addr)) / DMA_LEN_W'(DMA_BYTES);
    beats = beats_left;
    if (beats > DMA_LEN_W'(DMA_MAX_BURST_LEN)) beats = DMA_LEN_W'(DMA_MAX_BURST_LEN);
    if (beats > to_4k) beats = to_4k;
    return beats;
  endfunction

endpackage

// File: rtl/soc_dma_burst_sequencer_if.sv
// Request, burst-command, completion and status signals of the DMA burst sequencer.
interface soc_dma_burst_sequencer_if #(
  parameter int AW = soc_cfg_pkg::AXI_AW,
  parameter int LW = soc_cfg_pkg::DMA_LEN_W
);
  // Handshakes (req, cmd): a transfer happens on a rising clk edge where valid
  // and ready are both high; once valid is raised it and its payload stay
  // stable until that edge. rsp_valid_i is a one-cycle pulse per completed burst.
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [LW-1:0] req_bytes_i;
  logic          req_write_i;
  logic          cmd_valid_o;
  logic          cmd_ready_i;
  logic [AW-1:0] cmd_addr_o;
  logic [7:0]    cmd_len_o;
  logic          cmd_write_o;
  logic          rsp_valid_i;
  logic          rsp_err_i;
  logic          done_o;
  logic          err_o;
  logic          busy_o;

  // master: the sequencer itself; slave: DMA front-end plus AXI side.
  modport master (
    input  req_valid_i, req_addr_i, req_bytes_i, req_write_i,
    output req_ready_o,
    output cmd_valid_o, cmd_addr_o, cmd_len_o, cmd_write_o,
    input  cmd_ready_i,
    input  rsp_valid_i, rsp_err_i,
    output done_o, err_o, busy_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_bytes_i, req_write_i,
    input  req_ready_o,
    input  cmd_valid_o, cmd_addr_o, cmd_len_o, cmd_write_o,
    output cmd_ready_i,
    output rsp_valid_i, rsp_err_i,
    input  done_o, err_o, busy_o
  );

endinterface

// File: rtl/soc_dma_burst_sequencer.sv
// Splits one DMA transfer into AXI AW/AR burst commands (capped length, no 4 KiB
// crossing), bounds in-flight bursts and reports done/error per transfer.
module soc_dma_burst_sequencer
  import soc_cfg_pkg::*;
#(
  parameter int AXI_AW          = soc_cfg_pkg::AXI_AW,
  parameter int AXI_DW          = soc_cfg_pkg::AXI_DW,
  parameter int MAX_BURST_LEN   = soc_cfg_pkg::DMA_MAX_BURST_LEN,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_W           = soc_cfg_pkg::DMA_LEN_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  soc_dma_burst_sequencer_if.master  bus,
  output logic [1:0]                 dbg_state
);

  localparam int BYTES = AXI_DW / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [AXI_AW-1:0]  addr_q;
  logic [LEN_W-1:0]   beats_left_q;
  logic               write_q;
  logic               err_q;
  logic [OUT_W-1:0]   outstanding_q;

  logic               req_fire;
  logic               req_bad;
  logic               cmd_valid;
  logic               cmd_fire;
  logic               rsp_take;
  logic               last_burst;
  logic [LEN_W-1:0]   burst;

  assign req_fire = (state_q == IDLE) && bus.req_valid_i;
  assign req_bad  = (bus.req_bytes_i == '0) ||
                    (bus.req_addr_i[OFF_W-1:0] != '0) ||
                    (bus.req_bytes_i[OFF_W-1:0] != '0);

  // Module-level cap applied on top of the shared helper in case this
  // instance is configured tighter than the SoC default.
  always_comb begin
    burst = LEN_W'(burst_beats(addr_q[11:0], DMA_LEN_W'(beats_left_q)));
    if (burst > LEN_W'(MAX_BURST_LEN)) burst = LEN_W'(MAX_BURST_LEN);
  end

  assign cmd_valid  = (state_q == ISSUE) && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
  assign cmd_fire   = cmd_valid && bus.cmd_ready_i;
  assign rsp_take   = bus.rsp_valid_i && (outstanding_q != '0);
  assign last_burst = (burst == beats_left_q);

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.cmd_valid_o = cmd_valid;
  assign bus.cmd_addr_o  = addr_q;
  assign bus.cmd_len_o   = (state_q == ISSUE) ? 8'(burst - LEN_W'(1)) : 8'd0;
  assign bus.cmd_write_o = write_q;
  assign bus.done_o      = (state_q == DONE);
  assign bus.err_o       = (state_q == DONE) && err_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign dbg_state       = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_fire) state_d = req_bad ? DONE : ISSUE;
      ISSUE: if (cmd_fire && last_burst) state_d = DRAIN;
      // Look ahead at the emptying response so DONE follows it directly.
      DRAIN: if ((outstanding_q == '0) ||
                 (rsp_take && (outstanding_q == OUT_W'(1)))) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      beats_left_q  <= '0;
      write_q       <= 1'b0;
      err_q         <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        addr_q       <= bus.req_addr_i;
        beats_left_q <= LEN_W'(bus.req_bytes_i >> OFF_W);
        write_q      <= bus.req_write_i;
      end else if (cmd_fire) begin
        addr_q       <= addr_q + (AXI_AW'(burst) << OFF_W);
        beats_left_q <= beats_left_q - burst;
      end
      if (req_fire)                       err_q <= req_bad;
      else if (rsp_take && bus.rsp_err_i) err_q <= 1'b1;
      if (cmd_fire && !rsp_take)          outstanding_q <= outstanding_q + OUT_W'(1);
      else if (!cmd_fire && rsp_take)     outstanding_q <= outstanding_q - OUT_W'(1);
    end
  end

  rsp_without_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.rsp_valid_i && (outstanding_q == '0)));

endmodule
